// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter's newd/dintx inputs.
// Host pushes with wr_en/wr_data; bytes drain one at a time, paced by the
// start bit seen on tx_mon and the rising edge of donetx.
// Ports: clk, rst (async active-low); wr_en, wr_data -> full, empty, count;
// newd, dintx -> transmitter; tx_mon, donetx <- transmitter;
// busy, overflow, timeout_err (sticky), clr_err.
module uart_tx_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       newd,
    output logic [7:0]                 dintx,
    input  logic                       tx_mon,
    input  logic                       donetx,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout_err,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          donetx_q;

    logic pop;
    logic push;
    logic ovf_set;
    logic to_hit;
    logic to_set;
    logic done_rise;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != S_IDLE);
    assign pop       = (state == S_IDLE) && !empty;
    // A full FIFO still accepts a write when a pop frees a slot this cycle.
    assign push      = wr_en && (!full || pop);
    assign ovf_set   = wr_en && full && !pop;
    assign done_rise = donetx && !donetx_q;
    assign tcnt_nxt  = tcnt + 1'b1;
    assign to_hit    = (tcnt_nxt == TW'(TIMEOUT_CYCLES));
    assign to_set    = busy && to_hit;

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= S_IDLE;
            tcnt        <= '0;
            newd        <= 1'b0;
            dintx       <= 8'h00;
            donetx_q    <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            donetx_q <= donetx;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Set wins over a coincident clear.
            overflow    <= ovf_set | (overflow & ~clr_err);
            timeout_err <= to_set | (timeout_err & ~clr_err);

            // Timeout takes priority over start-bit and completion events.
            unique case (state)
                S_IDLE: begin
                    tcnt <= '0;
                    newd <= 1'b0;
                    if (pop) begin
                        dintx <= mem[rd_ptr];
                        newd  <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tcnt <= tcnt_nxt;
                    if (to_hit) begin
                        newd  <= 1'b0;
                        state <= S_IDLE;
                    end else if (!tx_mon) begin
                        newd  <= 1'b0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tcnt <= tcnt_nxt;
                    newd <= 1'b0;
                    if (to_hit || done_rise) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tcnt  <= '0;
                    newd  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized bench for uart_tx_fifo,
// checked every cycle against a queue-based behavioural model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 300;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       newd;
    logic [7:0] dintx;
    logic       tx_mon;
    logic       donetx;
    logic       busy;
    logic       overflow;
    logic       timeout_err;
    logic       clr_err;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .newd(newd),
        .dintx(dintx), .tx_mon(tx_mon), .donetx(donetx), .busy(busy),
        .overflow(overflow), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: queue of pending bytes plus the byte in flight.
    // phase 0 = nothing in flight, 1 = requesting, 2 = frame on the line.
    logic [7:0] mq[$];
    int         m_ph;
    int         m_age;
    logic       m_newd;
    logic [7:0] m_dintx;
    logic       m_dq;
    logic       m_ovf;
    logic       m_to;

    task automatic model_reset();
        mq.delete();
        m_ph = 0; m_age = 0; m_newd = 0; m_dintx = 8'h00;
        m_dq = 0; m_ovf = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit was_full, do_pop, ovf_s, to_s, rise;
        was_full = (mq.size() == DEPTH);
        do_pop   = (m_ph == 0) && (mq.size() != 0);
        ovf_s    = wr_en && was_full && !do_pop;
        rise     = donetx && !m_dq;
        to_s     = 0;
        if (m_ph == 0) begin
            m_age  = 0;
            m_newd = 0;
            if (do_pop) begin
                m_dintx = mq.pop_front();
                m_newd  = 1;
                m_ph    = 1;
            end
        end else begin
            m_age++;
            if (m_age == TO) begin
                to_s = 1; m_ph = 0; m_newd = 0;
            end else if (m_ph == 1 && !tx_mon) begin
                m_ph = 2; m_newd = 0;
            end else if (m_ph == 2 && rise) begin
                m_ph = 0;
            end
        end
        if (wr_en && (!was_full || do_pop)) mq.push_back(wr_data);
        m_dq  = donetx;
        m_ovf = ovf_s | (m_ovf & ~clr_err);
        m_to  = to_s | (m_to & ~clr_err);
    endtask

    always @(posedge clk) begin
        if (!rst) model_reset();
        else      model_step();
        #1;
        chk("count", count, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("newd", newd, m_newd);
        chk("dintx", dintx, m_dintx);
        chk("busy", busy, m_ph != 0);
        chk("overflow", overflow, m_ovf);
        chk("timeout_err", timeout_err, m_to);
    end

    int   pulses = 0;
    logic newd_prev = 1'b0;
    always @(posedge clk) begin
        #2;
        if (newd && !newd_prev) pulses++;
        newd_prev = newd;
    end

    task automatic wait_newd();
        for (int k = 0; k < 50 && !newd; k++) @(negedge clk);
        if (!newd) chk("newd_wait", 0, 1);
    endtask

    task automatic send_frame(output logic [7:0] b);
        wait_newd();
        b = dintx;
        tx_mon = 1'b0;
        @(negedge clk);
        tx_mon = 1'b1;
        repeat (2) @(negedge clk);
        donetx = 1'b1;
        @(negedge clk);
        donetx = 1'b0;
    endtask

    initial begin
        logic [7:0] cap [3];
        rst = 0; wr_en = 0; wr_data = 0; tx_mon = 1; donetx = 0; clr_err = 0;
        repeat (3) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_newd", newd, 0);
        chk("rst_dintx", dintx, 8'h00);
        chk("rst_flags", {busy, overflow, timeout_err}, 0);
        rst = 1;

        // Single byte latency and hand-off.
        @(negedge clk);
        wr_en = 1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 0;
        chk("lat_count1", count, 1);
        chk("lat_newd0", newd, 0);
        @(negedge clk);
        chk("lat_newd1", newd, 1);
        chk("lat_dintx", dintx, 8'hA5);
        chk("lat_busy", busy, 1);
        tx_mon = 0;
        @(negedge clk);
        tx_mon = 1;
        chk("start_newd", newd, 0);
        chk("start_busy", busy, 1);
        repeat (3) @(negedge clk);
        donetx = 1;
        @(negedge clk);
        donetx = 0;
        chk("done_busy", busy, 0);

        // Three bytes in order.
        pulses = 0;
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1; wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        for (int i = 0; i < 3; i++) send_frame(cap[i]);
        @(negedge clk);
        chk("seq_b0", cap[0], 8'h01);
        chk("seq_b1", cap[1], 8'h02);
        chk("seq_b2", cap[2], 8'h03);
        chk("seq_pulses", pulses, 3);
        chk("seq_empty", empty, 1);

        // Fill with transmitter stalled, then overflow.
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; wr_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_ovf", overflow, 0);
        wr_en = 1; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
        chk("ovf_clr", overflow, 0);

        // Timeout abandons byte 0x10, then 0x11 is issued.
        for (int k = 0; k < 2 * TO && !timeout_err; k++) @(negedge clk);
        chk("to_flag", timeout_err, 1);
        chk("to_newd", newd, 0);
        chk("to_busy", busy, 0);
        @(negedge clk);
        chk("to_next_newd", newd, 1);
        chk("to_next_dintx", dintx, 8'h11);
        chk("to_next_count", count, 15);

        // Asynchronous reset mid-frame.
        #2 rst = 0;
        #1;
        chk("arst_newd", newd, 0);
        chk("arst_count", count, 0);
        chk("arst_flag", timeout_err, 0);
        @(negedge clk);
        rst = 1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {busy, newd, empty}, 3'b001);

        // donetx already high on entry to WAIT_DONE.
        wr_en = 1; wr_data = 8'h5A;
        @(negedge clk);
        wr_en = 0;
        @(negedge clk);
        chk("hold_newd", newd, 1);
        donetx = 1; tx_mon = 0;
        @(negedge clk);
        tx_mon = 1;
        repeat (5) @(negedge clk);
        chk("hold_busy", busy, 1);
        donetx = 0;
        @(negedge clk);
        chk("hold_busy2", busy, 1);
        donetx = 1;
        @(negedge clk);
        donetx = 0;
        chk("hold_done", busy, 0);

        // Randomized traffic; stall windows force overflow and timeout.
        for (int c = 0; c < 4000; c++) begin
            bit stall;
            stall   = (c % 1000) > 600;
            wr_en   = ($urandom_range(0, 99) < 35);
            wr_data = 8'($urandom);
            tx_mon  = stall ? 1'b1 : ($urandom_range(0, 99) >= 20);
            donetx  = stall ? 1'b0 : 1'($urandom_range(0, 1));
            clr_err = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end
        wr_en = 0; clr_err = 0; tx_mon = 1; donetx = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-buffering feeder that sits directly upstream of the UART transmitter.
- Accepts bytes from the host side with a write strobe and stores them in a DEPTH-entry FIFO.
- Drains one byte at a time into the transmitter's newd/dintx inputs, using the serial line (start bit) and donetx to pace hand-off.
- Runs entirely on the system clk; the transmitter's slower internal bit clock is tolerated by holding newd until the start bit is observed.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 4096, clk cycles allowed in ISSUE plus WAIT_DONE before the byte is abandoned; must exceed one full frame (~1100 clk at 1 MHz / 9600 baud).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, one byte per asserted cycle.
- wr_data  in  8  host byte.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  $clog2(DEPTH)+1  current occupancy.
- newd  out  1  new-data request to the transmitter.
- dintx  out  8  byte presented to the transmitter; stable while newd=1.
- tx_mon  in  1  transmitter serial output, monitored for the start bit.
- donetx  in  1  transmitter frame-complete flag.
- busy  out  1  high whenever state != IDLE.
- overflow  out  1  sticky: a write was dropped.
- timeout_err  out  1  sticky: a byte was abandoned on timeout.
- clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO flushed: count=0, empty=1, full=0.
  - newd=0, dintx=8'h00, busy=0, overflow=0, timeout_err=0.
  - State=IDLE, timeout counter=0, donetx_q=0.
  - Reset mid-frame drops newd immediately; the byte in flight and all queued bytes are lost.
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping naturally at DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - full = (count==DEPTH); empty = (count==0).
- Push:
  - wr_en && !full: store wr_data at wr_ptr.
  - wr_en && full && pop in the same cycle: push accepted, count stays DEPTH.
  - wr_en && full, no pop: byte dropped, overflow set next cycle.
- Sticky flags: clr_err clears overflow and timeout_err; if a set event coincides with clr_err, set wins.
- donetx_q: donetx registered every cycle; done_rise = donetx && !donetx_q.
- IDLE:
  - newd=0; timeout counter=0.
  - If !empty: pop head into dintx, assert newd next cycle, go ISSUE.
- ISSUE:
  - newd=1, dintx held; timeout counter increments.
  - When tx_mon==0 is sampled: newd=0 next cycle, go WAIT_DONE (counter keeps running).
- WAIT_DONE:
  - newd=0; counter increments.
  - On done_rise: go IDLE. Only the rising edge counts; a level already high is ignored.
- Timeout: counter reaching TIMEOUT_CYCLES in ISSUE or WAIT_DONE forces newd=0, sets timeout_err, returns to IDLE; the byte is discarded.
- Latency: wr_en to an empty, idle block gives count=1 on the next cycle and newd=1 on the cycle after that (2 clk).
- Back-to-back: the next pop happens in the first IDLE cycle after done_rise; newd is never asserted across two bytes without passing through IDLE.
- Writes and pops continue normally in every state; busy does not block host writes.

Test Plan:
- Reset, then write 8'hA5 once -> count=1 one clk later, newd=1 and dintx=8'hA5 two clk after wr_en; with a real transmitter (1 MHz, 9600) tx_mon shows frame 0,1,0,1,0,0,1,0,1,1; busy falls after donetx rises.
- Write 8'h01,8'h02,8'h03 back-to-back -> transmitter frames carry 01,02,03 in order; newd pulses exactly three times; empty=1 at the end.
- Write 17 bytes with transmitter stalled (tx_mon held 1) -> first byte popped into ISSUE, next 16 fill the FIFO, full=1, no overflow; one more write -> overflow=1, count stays 16; clr_err -> overflow=0.
- tx_mon held 1 for 4096 clk after newd -> timeout_err=1, newd=0, state IDLE, next queued byte issued.
- Assert rst mid-frame with count=5 -> newd=0 and count=0 immediately (asynchronous); after release, the block stays idle until a new write.
- donetx held high on entry to WAIT_DONE -> no completion until donetx falls and rises again.
